// File: rtl/comp_pkg.sv
// Shared definitions for the serial 2-bit-digit magnitude comparator:
// one-hot result encodings and the controller state type.
package comp_pkg;

  localparam logic [2:0] CMP_NONE = 3'b000;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_GT   = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/comp_slice.sv
// Combinational compare of one unsigned 2-bit digit pair, producing the
// one-hot comp_pkg result encoding.
module comp_slice
  import comp_pkg::*;
(
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [2:0] res_o
);

  always_comb begin
    res_o = CMP_EQ;
    if (a_i < b_i) begin
      res_o = CMP_LT;
    end else if (a_i > b_i) begin
      res_o = CMP_GT;
    end
  end

endmodule

// File: rtl/comp_serial.sv
// Serial unsigned comparator: walks the operands MSB-first, one 2-bit digit
// per cycle. Define COMP_SERIAL_EARLY_EXIT_EN to finish on the first unequal digit.
module comp_serial
  import comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [2:0]       out
);

  if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
    $error("comp_serial: WIDTH must be even and >= 2");
  end

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DIGITS - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       out_q;
  logic             busy_q, done_q;

  logic [2:0]       digit_d;
  logic [2:0]       out_d;
  logic             last_d;
  logic             leave_d;

  comp_slice u_slice (
    .a_i   (a_q[WIDTH-1 -: 2]),
    .b_i   (b_q[WIDTH-1 -: 2]),
    .res_o (digit_d)
  );

  // A locked result is sticky; an equal digit only becomes a result on the last one.
  always_comb begin
    last_d = (cnt_q == '0);
    out_d  = out_q;
    if (out_q == CMP_NONE) begin
      if ((digit_d != CMP_EQ) || last_d) begin
        out_d = digit_d;
      end
    end
`ifdef COMP_SERIAL_EARLY_EXIT_EN
    leave_d = last_d || (digit_d != CMP_EQ);
`else
    leave_d = last_d;
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      out_q   <= CMP_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_in) begin
            a_q     <= a_in;
            b_q     <= b_in;
            cnt_q   <= CNT_INIT;
            out_q   <= CMP_NONE;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q << 2;
          b_q   <= b_q << 2;
          out_q <= out_d;
          if (leave_d) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_out = busy_q;
  assign done_out = done_q;
  assign out      = out_q;

endmodule

// File: tb/tb_comp_serial.sv
// Self-checking bench for comp_serial (WIDTH=8): directed table, hand-written
// corner sequences and randomized operands checked against a behavioural model.
module tb_comp_serial;

  localparam int W = 8;

  logic         clk;
  logic         rstN;
  logic         start;
  logic [W-1:0] aIn, bIn;
  logic         busy, done;
  logic [2:0]   res;

  int checks = 0;
  int errors = 0;

`ifdef COMP_SERIAL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  comp_serial #(.WIDTH(W)) dut (
    .clk_in   (clk),
    .rst_n_in (rstN),
    .start_in (start),
    .a_in     (aIn),
    .b_in     (bIn),
    .busy_out (busy),
    .done_out (done),
    .out      (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] expOut;
    int         expLat;
  } vec_t;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: magnitude compare by plain arithmetic; digit count from the
  // position of the first differing base-4 digit.
  function automatic logic [2:0] modelOut(input logic [7:0] a, input logic [7:0] b);
    if (a < b) return 3'b001;
    if (a > b) return 3'b100;
    return 3'b010;
  endfunction

  function automatic int modelLat(input logic [7:0] a, input logic [7:0] b);
    int k;
    k = W / 2;
    if (EARLY) begin
      for (int d = 0; d < W / 2; d++) begin
        if (((a >> (W - 2 - 2 * d)) & 8'd3) != ((b >> (W - 2 - 2 * d)) & 8'd3)) begin
          k = d + 1;
          break;
        end
      end
    end
    return k + 1;
  endfunction

  // One comparison: start pulsed for one cycle, operands scrambled after
  // capture; cycles counted from raising start until done is seen.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               output logic [2:0] gotOut, output int gotLat,
                               output int gotBusy);
    @(posedge clk); #1;
    aIn = a; bIn = b; start = 1'b1;
    gotLat = -1; gotBusy = 0; gotOut = 3'b000;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        start = 1'b0;
        aIn = 8'($urandom);
        bIn = 8'($urandom);
      end
      if (busy) gotBusy++;
      if (done) begin
        gotLat = n;
        gotOut = res;
        break;
      end
    end
  endtask

  task automatic runAndCheck(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] expOut, input int expLat);
    logic [2:0] gotOut;
    int gotLat, gotBusy;
    applyStimulus(a, b, gotOut, gotLat, gotBusy);
    checkOutput({name, " out"}, gotOut, expOut);
    checkOutput({name, " latency"}, gotLat, expLat);
    checkOutput({name, " busy cycles"}, gotBusy, expLat);
    @(posedge clk); #1;
    checkOutput({name, " done one cycle"}, done, 0);
    checkOutput({name, " idle busy"}, busy, 0);
    checkOutput({name, " out held"}, res, expOut);
  endtask

  vec_t vecs[$];

  initial begin
    logic [7:0] ra, rb;
    int doneCount, lat;

    rstN = 1'b0; start = 1'b0; aIn = '0; bIn = '0;
    #12;
    checkOutput("reset out", res, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    @(negedge clk); rstN = 1'b1;

    vecs.push_back('{8'hA5, 8'hA5, 3'b010, 5});
    vecs.push_back('{8'h80, 8'h7F, 3'b100, EARLY ? 2 : 5});
    vecs.push_back('{8'h12, 8'h13, 3'b001, 5});
    vecs.push_back('{8'h00, 8'h00, 3'b010, 5});
    vecs.push_back('{8'hFF, 8'hFF, 3'b010, 5});
    vecs.push_back('{8'h00, 8'hFF, 3'b001, EARLY ? 2 : 5});
    vecs.push_back('{8'h34, 8'h24, 3'b100, EARLY ? 3 : 5});
    vecs.push_back('{8'h5C, 8'h58, 3'b100, EARLY ? 4 : 5});
    foreach (vecs[i]) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].expOut, vecs[i].expLat);
    end

    // Start held high throughout, operands changed right after capture.
    @(posedge clk); #1;
    aIn = 8'h40; bIn = 8'h30; start = 1'b1;
    doneCount = 0; lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin aIn = 8'h00; bIn = 8'hFF; end
      if (done) begin doneCount++; lat = n; checkOutput("hold out", res, 3'b100); break; end
    end
    checkOutput("hold latency", lat, EARLY ? 2 : 5);
    @(posedge clk); #1;
    checkOutput("hold idle busy", busy, 0);
    checkOutput("hold idle done", done, 0);
    checkOutput("hold idle out", res, 3'b100);
    @(posedge clk); #1;
    checkOutput("hold restart busy", busy, 1);
    checkOutput("hold restart out cleared", res, 0);
    start = 1'b0;
    lat = -1;
    for (int n = 2; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done) begin doneCount++; lat = n; checkOutput("hold second out", res, 3'b001); break; end
    end
    checkOutput("hold second latency", lat, EARLY ? 2 : 5);
    checkOutput("hold done pulses", doneCount, 2);

    // Reset asserted during the second RUN cycle.
    @(posedge clk); #1;
    aIn = 8'h80; bIn = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rstN = 1'b0;
    #1;
    checkOutput("async reset out", res, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset done", done, 0);
    @(negedge clk); rstN = 1'b1;
    doneCount = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (done) doneCount++;
    end
    checkOutput("abort no done", doneCount, 0);
    runAndCheck("after reset", 8'h01, 8'h02, 3'b001, 5);

    // Randomized operands, biased toward shared leading digits.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ 8'($urandom_range(0, 3));
        2: rb = ra ^ 8'($urandom_range(0, 63));
        default: rb = 8'($urandom);
      endcase
      runAndCheck($sformatf("rand%0d", i), ra, rb, modelOut(ra, rb), modelLat(ra, rb));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
